alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Sequential execute unit that generalises the single-cycle integer ALU to a parametrised XLEN.
- Adds the RV32M/RV64M multiply, divide and remainder ops.
- Base ALU ops complete in one cycle; multiply and divide iterate internally.
- Sits in the EX stage behind the issue logic; talks to issue and writeback through valid/ready handshakes; has a flush input for pipeline kills.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- MUL_BITS, 2, multiplier bits retired per cycle; legal values 1, 2 or 4; must divide XLEN.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  request valid
- o_ready  out  1  unit can accept a request
- i_op  in  5  mdu_op_t operation
- i_a  in  XLEN  operand A
- i_b  in  XLEN  operand B
- i_flush  in  1  abort current operation
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_result  out  XLEN  result
- o_busy  out  1  state is MUL or DIV

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, o_valid=0, o_result=0, o_busy=0, all internal accumulators and counters cleared. o_ready=1 once the unit is in IDLE.
- Handshake rules:
  - A request is accepted when i_valid && o_ready.
  - o_ready = (state==IDLE). The unit is single-issue.
  - A result is consumed when o_valid && i_ready.
  - o_result and o_valid are held stable until consumed.
- States: IDLE, MUL, DIV, DONE.
  - IDLE, base op accepted: compute the result with ALU semantics, register it, go to DONE. Latency 1: o_valid rises the cycle after acceptance.
  - Base op semantics: ADD, SUB, OR, AND, XOR, SLT, SLTU, SLL, SRL, SRA. Shift amount is i_b[log2(XLEN)-1:0]. SLT and SLTU return zero-extended 1 or 0.
  - IDLE, MUL/MULH/MULHSU/MULHU: latch the operands, sign-extended to XLEN+1 bits per op signedness. Go to MUL with count=XLEN/MUL_BITS.
  - MUL state: each cycle add MUL_BITS partial products to a 2*XLEN accumulator (signed radix handling per operand signedness) and decrement count. At count==1, go to DONE with result = low half (MUL) or high half (MULH*). Latency = XLEN/MUL_BITS + 1 (17 for defaults).
  - IDLE, DIV/DIVU/REM/REMU, special cases resolved in one cycle, straight to DONE with latency 1:
    - Divisor zero: quotient = all ones; remainder = dividend.
    - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend; remainder = 0.
  - IDLE, DIV/DIVU/REM/REMU, all other cases: take magnitudes, go to DIV with count=XLEN. Restoring division, 1 bit per cycle.
  - DIV state exit: on the final step, fix signs (quotient negative iff operand signs differ; remainder takes the dividend sign) and go to DONE. Latency = XLEN + 1 (33 for defaults).
  - DONE: o_valid=1. On i_ready, go to IDLE; o_valid falls the next cycle.
- Flush:
  - i_flush in any state: go to IDLE next cycle, drop o_valid, no result delivered.
  - i_flush takes priority over a simultaneous i_valid in IDLE (request not accepted) and over i_ready in DONE.
- Illegal i_op encoding: result 0, latency 1.
- Count never wraps; it is loaded only in IDLE.
- o_busy = (state==MUL || state==DIV).

Decomposition:
- Package mdu_pkg:
  - mdu_op_t: 5-bit enum covering the 10 base ops plus MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - mdu_state_t.
  - Helpers is_mul(op), is_div(op), is_signed_a(op), is_signed_b(op).
- One sub-module, mdu_divider: iterative restoring divider with start/done, instantiated by alu_mdu.
- Base ALU logic and the multiplier stay inline in alu_mdu.

Test Plan:
- Base ops: ADD 0x7FFFFFFF+1 -> 0x80000000, o_valid one cycle after accept. SRA 0x80000000 by 4 -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF. All with latency 17.
- DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, latency 33. DIVU 100/7 -> 14.
- Edge cases: DIV x/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same pair -> 0. All with latency 1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_result and o_valid stable, o_ready=0. Release -> IDLE and o_ready=1 the next cycle.
- Flush and reset: i_flush at cycle 10 of a DIV -> IDLE next cycle, no o_valid, next ADD correct. Assert i_rst_n=0 mid-MUL -> outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and opcode-class helpers for the ALU / multiply-divide execute unit.
package mdu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_OR     = 5'd2,
    OP_AND    = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLTU   = 5'd6,
    OP_SLL    = 5'd7,
    OP_SRL    = 5'd8,
    OP_SRA    = 5'd9,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  function automatic logic is_mul(mdu_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div(mdu_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(mdu_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(mdu_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(mdu_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// o_done is high during the final step; the outputs then carry the sign-fixed result.
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_neg_q,
  input  logic            i_neg_r,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic            busy_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;

  // The partial remainder stays below the divisor, so XLEN+1 bits hold the trial sign.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[XLEN]) begin
      rem_d = trial[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_d = shifted[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  assign o_done      = busy_q && (cnt_q == CW'(1));
  assign o_quotient  = neg_q_q ? (~quo_d + 1'b1) : quo_d;
  assign o_remainder = neg_r_q ? (~rem_d + 1'b1) : rem_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q  <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else if (i_start) begin
      busy_q  <= 1'b1;
      neg_q_q <= i_neg_q;
      neg_r_q <= i_neg_r;
      cnt_q   <= CW'(XLEN);
      rem_q   <= '0;
      quo_q   <= i_dividend;
      dvs_q   <= i_divisor;
    end else if (i_abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage execute unit: single-cycle ALU ops plus iterative RV M-extension multiply/divide.
//   state | meaning
//   IDLE  | ready for a request
//   MUL   | radix-2^MUL_BITS multiply in progress
//   DIV   | restoring divide in progress (mdu_divider)
//   DONE  | result held on o_result until consumed
module alu_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  mdu_op_t         i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int SHW       = $clog2(XLEN);
  localparam int CW        = $clog2(XLEN + 1);
  localparam int MUL_STEPS = XLEN / MUL_BITS;

  mdu_state_t        state_q, state_d;
  mdu_op_t           op_q;
  logic [XLEN-1:0]   result_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [CW-1:0]     cnt_q;

  logic              accept;
  logic [XLEN-1:0]   alu_res;
  logic [SHW-1:0]    shamt;
  logic              a_neg, b_neg;
  logic              div_zero, div_ovf, div_start;
  logic [XLEN-1:0]   div_special;
  logic [2*XLEN-1:0] a_sx, acc_init, pp, acc_next;
  logic              div_done;
  logic [XLEN-1:0]   div_quo, div_rem;

  assign accept = i_valid && (state_q == IDLE) && !i_flush;
  assign shamt  = i_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (i_op)
      OP_ADD:  alu_res = i_a + i_b;
      OP_SUB:  alu_res = i_a - i_b;
      OP_OR:   alu_res = i_a | i_b;
      OP_AND:  alu_res = i_a & i_b;
      OP_XOR:  alu_res = i_a ^ i_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, i_a < i_b};
      OP_SLL:  alu_res = i_a << shamt;
      OP_SRL:  alu_res = i_a >> shamt;
      OP_SRA:  alu_res = $signed(i_a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Divide corner cases resolve without the iterative divider.
  always_comb begin
    a_neg       = is_signed_a(i_op) && i_a[XLEN-1];
    b_neg       = is_signed_b(i_op) && i_b[XLEN-1];
    div_zero    = (i_b == '0);
    div_ovf     = is_signed_b(i_op) && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (&i_b);
    div_start   = accept && is_div(i_op) && !div_zero && !div_ovf;
    div_special = '0;
    if (div_zero)     div_special = is_rem(i_op) ? i_a : '1;
    else if (div_ovf) div_special = is_rem(i_op) ? '0 : i_a;
  end

  // Low multiplier bits are taken unsigned; a negative B is folded in up front as -A*2^XLEN.
  always_comb begin
    a_sx     = a_neg ? {{XLEN{1'b1}}, i_a} : {{XLEN{1'b0}}, i_a};
    acc_init = b_neg ? ('0 - (a_sx << XLEN)) : '0;
    pp       = mcand_q * {{(2*XLEN-MUL_BITS){1'b0}}, mplier_q[MUL_BITS-1:0]};
    acc_next = acc_q + pp;
  end

  mdu_divider #(.XLEN(XLEN)) u_divider (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (div_start),
    .i_abort     (i_flush),
    .i_dividend  (a_neg ? (~i_a + 1'b1) : i_a),
    .i_divisor   (b_neg ? (~i_b + 1'b1) : i_b),
    .i_neg_q     (a_neg ^ b_neg),
    .i_neg_r     (a_neg),
    .o_done      (div_done),
    .o_quotient  (div_quo),
    .o_remainder (div_rem)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (is_mul(i_op))                                state_d = MUL;
        else if (is_div(i_op) && !div_zero && !div_ovf) state_d = DIV;
        else                                             state_d = DONE;
      end
      MUL:  if (i_flush) state_d = IDLE; else if (cnt_q == CW'(1)) state_d = DONE;
      DIV:  if (i_flush) state_d = IDLE; else if (div_done) state_d = DONE;
      DONE: if (i_flush || i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q     <= OP_ADD;
      result_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q <= i_op;
          if (is_mul(i_op)) begin
            acc_q    <= acc_init;
            mcand_q  <= a_sx;
            mplier_q <= i_b;
            cnt_q    <= CW'(MUL_STEPS);
          end else if (is_div(i_op)) begin
            result_q <= div_special;
          end else begin
            result_q <= alu_res;
          end
        end
        MUL: if (!i_flush) begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << MUL_BITS;
          mplier_q <= mplier_q >> MUL_BITS;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == CW'(1))
            result_q <= (op_q == OP_MUL) ? acc_next[XLEN-1:0] : acc_next[2*XLEN-1:XLEN];
        end
        DIV: if (!i_flush && div_done) result_q <= is_rem(op_q) ? div_rem : div_quo;
        default: ;
      endcase
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_busy   = (state_q == MUL) || (state_q == DIV);
  assign o_result = result_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed vector bench for alu_mdu (XLEN=32, MUL_BITS=2): results, latency, handshake, flush, reset.
module tb_alu_mdu;
  import mdu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  mdu_op_t     i_op;
  logic [31:0] i_a, i_b;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_mdu #(.XLEN(32), .MUL_BITS(2)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issue one request and wait for o_valid; returns with the result still held (not yet consumed).
  task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit got);
    @(negedge i_clk);
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    got = o_valid;
    res = o_result;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    bit          got;
    bit          stable;
    bit          leaked;

    add_vec(OP_ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
    add_vec(OP_SUB,    32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1);
    add_vec(OP_OR,     32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1);
    add_vec(OP_AND,    32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1);
    add_vec(OP_XOR,    32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1);
    add_vec(OP_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
    add_vec(OP_SLTU,   32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1);
    add_vec(OP_SLL,    32'h00000001, 32'h00000021, 32'h00000002, 1);
    add_vec(OP_SRL,    32'h80000000, 32'h00000004, 32'h08000000, 1);
    add_vec(OP_SRA,    32'h80000000, 32'h00000004, 32'hF8000000, 1);
    add_vec(OP_MUL,    32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 17);
    add_vec(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 17);
    add_vec(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 17);
    add_vec(OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 17);
    add_vec(OP_MULH,   32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 17);
    add_vec(OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
    add_vec(OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
    add_vec(OP_DIVU,   32'd100,      32'd7,        32'd14,       33);
    add_vec(OP_REMU,   32'd100,      32'd7,        32'd2,        33);
    add_vec(OP_DIV,    32'h80000000, 32'h00000002, 32'hC0000000, 33);
    add_vec(OP_DIV,    32'd12345,    32'h00000000, 32'hFFFFFFFF, 1);
    add_vec(OP_REMU,   32'd5,        32'h00000000, 32'd5,        1);
    add_vec(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    add_vec(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    add_vec(mdu_op_t'(5'd12), 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1);

    i_rst_n = 1'b0; i_valid = 1'b0; i_op = OP_ADD; i_a = '0; i_b = '0;
    i_flush = 1'b0; i_ready = 1'b1;
    #12;
    check("reset_valid",  {31'd0, o_valid},  32'd0);
    check("reset_ready",  {31'd0, o_ready},  32'd1);
    check("reset_busy",   {31'd0, o_busy},   32'd0);
    check("reset_result", o_result,          32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, got);
      check($sformatf("vec%0d_%s_valid", i, vecs[i].op.name()), {31'd0, got}, 32'd1);
      check($sformatf("vec%0d_%s_result", i, vecs[i].op.name()), res, vecs[i].exp);
      check($sformatf("vec%0d_%s_latency", i, vecs[i].op.name()), lat, vecs[i].lat);
      @(posedge i_clk);
      #1;
    end

    // Backpressure: result held for 5 cycles, then released.
    i_ready = 1'b0;
    issue(OP_ADD, 32'd3, 32'd4, res, lat, got);
    check("bp_first_result", res, 32'd7);
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clk);
      #1;
      if (!(o_valid && o_result == 32'd7 && !o_ready)) stable = 1'b0;
    end
    check("bp_held_stable", {31'd0, stable}, 32'd1);
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    check("bp_release_ready", {31'd0, o_ready}, 32'd1);
    check("bp_release_valid", {31'd0, o_valid}, 32'd0);

    // Flush wins over i_ready in DONE.
    i_ready = 1'b0;
    issue(OP_ADD, 32'd1, 32'd1, res, lat, got);
    @(negedge i_clk);
    i_flush = 1'b1; i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    check("flush_done_valid", {31'd0, o_valid}, 32'd0);
    check("flush_done_ready", {31'd0, o_ready}, 32'd1);

    // Flush wins over a simultaneous request in IDLE.
    @(negedge i_clk);
    i_flush = 1'b1; i_valid = 1'b1; i_op = OP_ADD; i_a = 32'd9; i_b = 32'd9;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0; i_valid = 1'b0;
    check("flush_idle_ready", {31'd0, o_ready}, 32'd1);
    check("flush_idle_valid", {31'd0, o_valid}, 32'd0);

    // Flush at cycle 10 of a divide.
    @(negedge i_clk);
    i_valid = 1'b1; i_op = OP_DIVU; i_a = 32'd100; i_b = 32'd7;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    for (int c = 0; c < 8; c++) @(posedge i_clk);
    #1;
    check("div_busy_before_flush", {31'd0, o_busy}, 32'd1);
    @(negedge i_clk);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    check("div_flush_ready", {31'd0, o_ready}, 32'd1);
    check("div_flush_busy",  {31'd0, o_busy},  32'd0);
    leaked = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge i_clk);
      #1;
      if (o_valid) leaked = 1'b1;
    end
    check("div_flush_no_valid", {31'd0, leaked}, 32'd0);
    issue(OP_ADD, 32'd5, 32'd6, res, lat, got);
    check("post_flush_add", res, 32'd11);
    check("post_flush_lat", lat, 32'd1);

    // Asynchronous reset in the middle of a multiply.
    i_ready = 1'b0;
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    i_valid = 1'b1; i_op = OP_MULHU; i_a = 32'hFFFFFFFF; i_b = 32'hFFFFFFFF;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    for (int c = 0; c < 5; c++) @(posedge i_clk);
    #1;
    check("mul_busy_before_reset", {31'd0, o_busy}, 32'd1);
    check("result_before_reset", o_result, 32'd11);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_reset_busy",   {31'd0, o_busy},  32'd0);
    check("async_reset_valid",  {31'd0, o_valid}, 32'd0);
    check("async_reset_ready",  {31'd0, o_ready}, 32'd1);
    check("async_reset_result", o_result,         32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, got);
    check("post_reset_mulhu", res, 32'hFFFFFFFE);
    check("post_reset_lat",   lat, 32'd17);
    @(posedge i_clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
